// File: rtl/ram_port_arbiter_if.sv
// Requester and RAM port bundle for the two-master RAM arbiter.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16
);
    // CPU requester
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              cpu_stall;

    // External master
    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ack;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;
    logic              ext_lock;

    // RAM port
    logic              ram_en;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_rvalid, cpu_stall,
        input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        output ext_ack, ext_rdata, ext_rvalid,
        output ram_en, ram_we, ram_re, ram_addr, ram_wdata,
        input  ram_rdata
    );

    // Requester / RAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid, cpu_stall,
        output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
        input  ext_ack, ext_rdata, ext_rvalid,
        input  ram_en, ram_we, ram_re, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU and an external
// master, with lockable ext bursts and owner-tagged read return.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk_main,
    input  logic              reset,
    ram_port_arbiter_if.slave bus
);
    // Tag depth equals read latency; clamped so an illegal 0 still elaborates.
    localparam int unsigned TAG_D = (RD_LAT < 1) ? 1 : RD_LAT;

    logic              cpu_ack_q;
    logic              ext_ack_q;
    logic              ram_we_q;
    logic              ram_re_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              last_ext_q;
    logic              locked_q;
    logic [TAG_D-1:0]  tag_vld_q;
    logic [TAG_D-1:0]  tag_ext_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              cpu_rvalid_q;
    logic              ext_rvalid_q;

    logic              cpu_elig_c;
    logic              ext_elig_c;
    logic              grant_cpu_c;
    logic              grant_ext_c;
    logic              grant_c;
    logic              win_we_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [DATA_W-1:0] win_wdata_c;

    // Eligibility masks the just-acked requester; ties go to whoever was not last.
    always_comb begin
        cpu_elig_c  = bus.cpu_req & ~cpu_ack_q & ~locked_q;
        ext_elig_c  = bus.ext_req & ~ext_ack_q;
        grant_cpu_c = cpu_elig_c & (~ext_elig_c | last_ext_q);
        grant_ext_c = ext_elig_c & ~grant_cpu_c;
        grant_c     = grant_cpu_c | grant_ext_c;
        win_we_c    = grant_ext_c ? bus.ext_we    : bus.cpu_we;
        win_addr_c  = grant_ext_c ? bus.ext_addr  : bus.cpu_addr;
        win_wdata_c = grant_ext_c ? bus.ext_wdata : bus.cpu_wdata;
    end

    // Register the winning access onto the RAM port and pulse its ack.
    always_ff @(posedge clk_main) begin
        if (!reset) begin
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_re_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            last_ext_q  <= 1'b1;
        end else begin
            cpu_ack_q <= grant_cpu_c;
            ext_ack_q <= grant_ext_c;
            ram_we_q  <= grant_c & win_we_c;
            ram_re_q  <= grant_c & ~win_we_c;
            if (grant_c) begin
                ram_addr_q  <= win_addr_c;
                ram_wdata_q <= win_wdata_c;
                last_ext_q  <= grant_ext_c;
            end
        end
    end

    // Lock engages only on an ext issue with ext_lock high; any low sample drops it.
    always_ff @(posedge clk_main) begin
        if (!reset) begin
            locked_q <= 1'b0;
        end else if (!bus.ext_lock) begin
            locked_q <= 1'b0;
        end else if (grant_ext_c) begin
            locked_q <= 1'b1;
        end
    end

    // Owner tag pipeline; last_ext_q names the owner of the strobe currently on the port.
    always_ff @(posedge clk_main) begin
        if (!reset) begin
            tag_vld_q <= '0;
            tag_ext_q <= '0;
        end else begin
            tag_vld_q <= TAG_D'({tag_vld_q, ram_re_q});
            tag_ext_q <= TAG_D'({tag_ext_q, last_ext_q});
        end
    end

    // Steer returning read data to the owner of the exiting tag.
    always_ff @(posedge clk_main) begin
        if (!reset) begin
            cpu_rdata_q  <= '0;
            ext_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            ext_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= tag_vld_q[TAG_D-1] & ~tag_ext_q[TAG_D-1];
            ext_rvalid_q <= tag_vld_q[TAG_D-1] &  tag_ext_q[TAG_D-1];
            if (tag_vld_q[TAG_D-1] && !tag_ext_q[TAG_D-1]) begin
                cpu_rdata_q <= bus.ram_rdata;
            end
            if (tag_vld_q[TAG_D-1] && tag_ext_q[TAG_D-1]) begin
                ext_rdata_q <= bus.ram_rdata;
            end
        end
    end

    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.ext_ack    = ext_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.ext_rdata  = ext_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.ext_rvalid = ext_rvalid_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_re     = ram_re_q;
    assign bus.ram_en     = ram_we_q | ram_re_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter: one instance at RD_LAT=1, one at RD_LAT=3.
`timescale 1ns/1ps
module tb_ram_port_arbiter;

    typedef struct {
        logic        ext;
        logic        we;
        logic [5:0]  addr;
        logic [15:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        logic        ext;
        logic [15:0] data;
        int          cyc;
    } rd_t;

    logic clk_main = 1'b0;
    logic reset;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    iss_t iss1[$];
    iss_t iss3[$];
    rd_t  rd1[$];
    rd_t  rd3[$];

    logic [15:0] mem1 [64];
    logic [15:0] mem3 [64];
    logic [15:0] p1;
    logic [15:0] p3 [3];

    ram_port_arbiter_if #(.ADDR_W(6), .DATA_W(16)) b1 ();
    ram_port_arbiter_if #(.ADDR_W(6), .DATA_W(16)) b3 ();

    ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .RD_LAT(1)) dut1 (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (b1)
    );

    ram_port_arbiter #(.ADDR_W(6), .DATA_W(16), .RD_LAT(3)) dut3 (
        .clk_main (clk_main),
        .reset    (reset),
        .bus      (b3)
    );

    always #5 clk_main = ~clk_main;
    always @(posedge clk_main) cyc <= cyc + 1;

    // RAM models: data valid RD_LAT cycles after the ram_re cycle
    always @(posedge clk_main) begin
        if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_wdata;
        p1 <= mem1[b1.ram_addr];
    end
    assign b1.ram_rdata = p1;

    always @(posedge clk_main) begin
        p3[0] <= mem3[b3.ram_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b3.ram_rdata = p3[2];

    task automatic tick();
        @(posedge clk_main);
        #1;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic exp_iss(input int d, input logic ext, input logic we,
                           input logic [5:0] a, input logic [15:0] w, input int c);
        iss_t e;
        e.ext = ext; e.we = we; e.addr = a; e.wdata = w; e.cyc = c;
        if (d == 1) iss1.push_back(e);
        else        iss3.push_back(e);
    endtask

    task automatic exp_rd(input int d, input logic ext, input logic [15:0] v, input int c);
        rd_t r;
        r.ext = ext; r.data = v; r.cyc = c;
        if (d == 1) rd1.push_back(r);
        else        rd3.push_back(r);
    endtask

    task automatic rd_check(input int d, input logic ext, input logic [15:0] data);
        rd_t r;
        bit  have;
        have = 1'b0;
        checks++;
        if (d == 1 && rd1.size() > 0) begin r = rd1.pop_front(); have = 1'b1; end
        if (d == 3 && rd3.size() > 0) begin r = rd3.pop_front(); have = 1'b1; end
        if (!have) begin
            errors++;
            $display("FAIL unexpected_rvalid dut%0d cyc %0d: ext %b data 0x%0h", d, cyc, ext, data);
        end else if (ext !== r.ext || data !== r.data || cyc != r.cyc) begin
            errors++;
            $display("FAIL rvalid dut%0d: got ext %b data 0x%0h cyc %0d want ext %b data 0x%0h cyc %0d",
                     d, ext, data, cyc, r.ext, r.data, r.cyc);
        end
    endtask

    task automatic mon(input int d, input logic ca, input logic ea, input logic en,
                       input logic we, input logic re, input logic [5:0] a,
                       input logic [15:0] wd, input logic crv, input logic erv,
                       input logic [15:0] crd, input logic [15:0] erd);
        iss_t e;
        bit   have;
        have = 1'b0;
        checks++;
        if (ca || ea) begin
            if (d == 1 && iss1.size() > 0) begin e = iss1.pop_front(); have = 1'b1; end
            if (d == 3 && iss3.size() > 0) begin e = iss3.pop_front(); have = 1'b1; end
            if (!have) begin
                errors++;
                $display("FAIL unexpected_ack dut%0d cyc %0d: cpu_ack %b ext_ack %b", d, cyc, ca, ea);
            end else if (ca === ea || ea !== e.ext || en !== 1'b1 || we !== e.we || re !== ~e.we ||
                         a !== e.addr || (e.we && wd !== e.wdata) || cyc != e.cyc) begin
                errors++;
                $display("FAIL issue dut%0d: got cyc %0d ack c%b/e%b en %b we %b re %b addr 0x%0h wdata 0x%0h want cyc %0d ext %b we %b addr 0x%0h wdata 0x%0h",
                         d, cyc, ca, ea, en, we, re, a, wd, e.cyc, e.ext, e.we, e.addr, e.wdata);
            end
        end else if (en || we || re) begin
            errors++;
            $display("FAIL idle_strobe dut%0d cyc %0d: got en %b we %b re %b want 0 0 0", d, cyc, en, we, re);
        end
        if (crv) rd_check(d, 1'b0, crd);
        if (erv) rd_check(d, 1'b1, erd);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an ack or rvalid
    always @(negedge clk_main) begin
        if (mon_en) begin
            mon(1, b1.cpu_ack, b1.ext_ack, b1.ram_en, b1.ram_we, b1.ram_re, b1.ram_addr,
                b1.ram_wdata, b1.cpu_rvalid, b1.ext_rvalid, b1.cpu_rdata, b1.ext_rdata);
            mon(3, b3.cpu_ack, b3.ext_ack, b3.ram_en, b3.ram_we, b3.ram_re, b3.ram_addr,
                b3.ram_wdata, b3.cpu_rvalid, b3.ext_rvalid, b3.cpu_rdata, b3.ext_rdata);
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: cyc %0d, bench did not finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem3[i] = 16'h0000;
        mem3[1] = 16'h1111;
        mem3[2] = 16'h2222;
    end

    initial begin
        int r0;
        int a0;
        int l0;
        int m0;
        int n0;

        reset = 1'b0;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 6'h10; b1.cpu_wdata = 16'h1234;
        b1.ext_req = 1'b1; b1.ext_we = 1'b1; b1.ext_addr = 6'h20; b1.ext_wdata = 16'h5678;
        b1.ext_lock = 1'b0;
        b3.cpu_req = 1'b0; b3.cpu_we = 1'b0; b3.cpu_addr = 6'h00; b3.cpu_wdata = 16'h0000;
        b3.ext_req = 1'b0; b3.ext_we = 1'b0; b3.ext_addr = 6'h00; b3.ext_wdata = 16'h0000;
        b3.ext_lock = 1'b0;

        // Reset held with both requests up
        tick();
        tick();
        mon_en = 1'b1;
        @(negedge clk_main);
        chk("rst_ram_addr",  32'(b1.ram_addr),  32'h0);
        chk("rst_ram_wdata", 32'(b1.ram_wdata), 32'h0);
        chk("rst_cpu_rdata", 32'(b1.cpu_rdata), 32'h0);
        chk("rst_ext_rdata", 32'(b1.ext_rdata), 32'h0);
        chk("rst_cpu_stall", 32'(b1.cpu_stall), 32'h1);
        chk("rst3_ram_addr", 32'(b3.ram_addr),  32'h0);

        // Release: contention alternates CPU, EXT starting with CPU
        tick();
        reset = 1'b1;
        r0 = cyc;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) exp_iss(1, 1'b0, 1'b1, 6'h10, 16'h1234, r0 + 1 + k);
            else            exp_iss(1, 1'b1, 1'b1, 6'h20, 16'h5678, r0 + 1 + k);
        end
        wait_to(r0 + 6);
        b1.cpu_req = 1'b0;
        b1.ext_req = 1'b0;

        // CPU write 0xBEEF to 0x2A, then read it back
        tick();
        tick();
        a0 = cyc;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 6'h2A; b1.cpu_wdata = 16'hBEEF;
        exp_iss(1, 1'b0, 1'b1, 6'h2A, 16'hBEEF, a0 + 1);
        exp_iss(1, 1'b0, 1'b0, 6'h2A, 16'hBEEF, a0 + 3);
        exp_rd (1, 1'b0, 16'hBEEF, a0 + 5);
        wait_to(a0 + 2);
        b1.cpu_we = 1'b0;
        wait_to(a0 + 4);
        b1.cpu_req = 1'b0;
        wait_to(a0 + 6);

        // Locked ext burst of 8 reads while CPU waits with a write
        tick();
        l0 = cyc;
        b1.ext_req = 1'b1; b1.ext_we = 1'b0; b1.ext_addr = 6'h2A; b1.ext_lock = 1'b1;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b1; b1.cpu_addr = 6'h05; b1.cpu_wdata = 16'h0055;
        for (int k = 0; k < 8; k++) begin
            exp_iss(1, 1'b1, 1'b0, 6'h2A, 16'h0000, l0 + 1 + 2 * k);
            exp_rd (1, 1'b1, 16'hBEEF, l0 + 3 + 2 * k);
        end
        exp_iss(1, 1'b0, 1'b1, 6'h05, 16'h0055, l0 + 18);
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 16) begin
                b1.ext_req  = 1'b0;
                b1.ext_lock = 1'b0;
            end
            @(negedge clk_main);
            chk("lock_cpu_stall", 32'(b1.cpu_stall), 32'h1);
        end
        tick();
        @(negedge clk_main);
        chk("unlock_cpu_stall", 32'(b1.cpu_stall), 32'h0);
        tick();
        b1.cpu_req = 1'b0;

        // Reset in the cycle after ram_re discards the read
        tick();
        m0 = cyc;
        b1.cpu_req = 1'b1; b1.cpu_we = 1'b0; b1.cpu_addr = 6'h05;
        exp_iss(1, 1'b0, 1'b0, 6'h05, 16'h0000, m0 + 1);
        wait_to(m0 + 2);
        b1.cpu_req = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk_main);
        chk("midrst_cpu_rdata", 32'(b1.cpu_rdata), 32'h0);
        chk("midrst_ram_addr",  32'(b1.ram_addr),  32'h0);
        tick();
        b1.cpu_req = 1'b1;
        exp_iss(1, 1'b0, 1'b0, 6'h05, 16'h0000, m0 + 5);
        exp_rd (1, 1'b0, 16'h0055, m0 + 7);
        wait_to(m0 + 6);
        b1.cpu_req = 1'b0;
        wait_to(m0 + 9);

        // RD_LAT=3: back-to-back CPU and ext reads, no cross-routing
        tick();
        n0 = cyc;
        b3.cpu_req = 1'b1; b3.cpu_we = 1'b0; b3.cpu_addr = 6'h01;
        b3.ext_req = 1'b1; b3.ext_we = 1'b0; b3.ext_addr = 6'h02;
        exp_iss(3, 1'b0, 1'b0, 6'h01, 16'h0000, n0 + 1);
        exp_iss(3, 1'b1, 1'b0, 6'h02, 16'h0000, n0 + 2);
        exp_rd (3, 1'b0, 16'h1111, n0 + 5);
        exp_rd (3, 1'b1, 16'h2222, n0 + 6);
        wait_to(n0 + 2);
        b3.cpu_req = 1'b0;
        wait_to(n0 + 3);
        b3.ext_req = 1'b0;
        wait_to(n0 + 10);
        @(negedge clk_main);

        chk("drain_iss1", 32'(iss1.size()), 32'h0);
        chk("drain_rd1",  32'(rd1.size()),  32'h0);
        chk("drain_iss3", 32'(iss3.size()), 32'h0);
        chk("drain_rd3",  32'(rd3.size()),  32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter sharing the single 64x16 data RAM port between the CPU datapath and an external master (program/data loader or debug reader). Each requester uses a req/ack handshake. The arbiter registers the winning request onto the RAM port and routes read data back to its owner, tagged through the RAM read latency. A lock input lets the external master hold the RAM for bulk transfers while the CPU stalls.

## Interface
- ADDR_W, 6, RAM address width
- DATA_W, 16, RAM data width
- RD_LAT, 1, RAM read latency in cycles from the ram_re cycle to valid ram_rdata (legal values 1..4)
- clk_main  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- cpu_req  in  1  CPU access request, held with fields stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle pulse: CPU access issued to RAM this cycle
- cpu_rdata  out  DATA_W  last read data returned to CPU
- cpu_rvalid  out  1  one-cycle pulse: cpu_rdata updated
- ext_req, ext_we, ext_addr, ext_wdata, ext_ack, ext_rdata, ext_rvalid: same as cpu_* for the external master
- ext_lock  in  1  while high after an ext grant, CPU is not eligible
- ram_en  out  1  ram_we | ram_re
- ram_we  out  1  RAM write strobe
- ram_re  out  1  RAM read strobe
- ram_addr  out  ADDR_W  registered address
- ram_wdata  out  DATA_W  registered write data
- ram_rdata  in  DATA_W  RAM read data
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)

## Operation
- Eligibility in cycle t:
  - cpu_elig = cpu_req & ~cpu_ack & ~locked.
  - ext_elig = ext_req & ~ext_ack.
  - The acked requester is masked for that cycle, so a held req is never double-granted.
- Winner selection:
  - Only one eligible: that requester wins.
  - Both eligible: the requester not granted last wins (round-robin pointer `last`).
- Issue (registered at the edge ending cycle t, so visible in t+1):
  - ram_addr and ram_wdata load from the winner.
  - ram_we = winner_we; ram_re = ~winner_we.
  - The winner's ack = 1.
  - `last` = winner.
- No winner: ram_en, ram_we, ram_re and both acks are 0; ram_addr and ram_wdata hold.
- Lock:
  - `locked` sets when an ext access issues with ext_lock = 1.
  - `locked` clears on any cycle ext_lock is sampled 0.
  - ext_lock has no effect until ext is actually granted.
- Read return:
  - Each ram_re cycle pushes {valid, owner} into an RD_LAT-deep tag pipeline.
  - At the tag's exit cycle (when ram_rdata is valid), the owner's rdata register captures ram_rdata and its rvalid pulses the next cycle.
  - rdata holds its value until the next read for that owner.
- Writes produce no rvalid.
- Requester contract: req and fields stay stable from assertion through the ack cycle. req may remain high to present the next access, which is first sampled the cycle after ack.

## Timing
- Reset (reset = 0 at a rising edge) forces:
  - All outputs to 0; cpu_stall follows cpu_req.
  - ram_addr, ram_wdata, cpu_rdata and ext_rdata to 0.
  - `last` to ext, so CPU wins the first tie.
  - `locked` to 0.
  - All tags cleared.
- Reset mid-read: in-flight reads are discarded and no rvalid is produced.
- Latency:
  - req sampled in cycle t: ack and RAM strobe in t+1.
  - ram_rdata valid in t+1+RD_LAT; rvalid and rdata in t+2+RD_LAT.
  - RD_LAT = 1: req@0, ack@1, rvalid@3.
- Throughput:
  - One RAM access per cycle when requesters alternate.
  - A single requester gets at most one access per 2 cycles (ack mask).
- Tag pipeline accepts one read per cycle; no backpressure on returns.

## Test plan
- Reset values: hold reset = 0 for 2 cycles with both reqs high -> all acks, strobes, rvalids, ram_addr and rdata = 0; first release cycle samples, so cpu_ack first appears 1 cycle after release.
- CPU write then read: write 0xBEEF to addr 0x2A, then read 0x2A (RD_LAT = 1) -> ram_we@1 with addr 0x2A and data 0xBEEF; read ram_re@3; cpu_rvalid@5 with cpu_rdata = 0xBEEF; ext_rvalid stays 0.
- Contention: both reqs held high continuously -> grants alternate CPU, EXT, CPU, EXT on consecutive cycles; ram_en high every cycle; each ack pulses every 2nd cycle.
- Lock burst: ext issues 8 reads with ext_lock = 1 while cpu_req is high -> zero cpu_acks during the burst and cpu_stall = 1; drop ext_lock -> cpu_ack within 2 cycles.
- Reset mid-read: reset asserted in the cycle after ram_re -> no cpu_rvalid follows; the next read returns correct data.
- RD_LAT = 3, mixed owners: CPU read addr 1 and ext read addr 2 back-to-back -> each rvalid arrives 5 cycles after its req sample with the correct owner's data; no cross-routing.
